// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit CPU core.
// Opcode class constants live in cpu_defs_pkg, shared with the rest of the core.
package cpu_defs_pkg;
    localparam logic [2:0] kLDM = 3'd4;
    localparam logic [2:0] kSTR = 3'd5;
    localparam logic [2:0] kBNE = 3'd6;
endpackage

module cpu_seq_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [2:0]       op,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             branch_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state, state_nx;

    logic             cls_ld;
    logic             cls_st;
    logic             cls_br;
    logic             br_taken;
    logic             halt_pend;
    logic             err_q;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] ret_q;
    logic             mem_last;

    // Last wait cycle before the memory handshake is declared dead
    assign mem_last = (tcnt == T_LAST);
    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign err      = err_q;
    assign retired  = ret_q;

    // State register
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state and Moore enables decoded from state and latched class
    always_comb begin
        state_nx   = state;
        pc_en      = 1'b0;
        branch_sel = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                ir_we    = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = (cls_ld || cls_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = cls_st;
                if (mem_ack)       state_nx = S_WB;
                else if (mem_last) state_nx = S_HALT;
            end
            S_WB: begin
                pc_en      = 1'b1;
                branch_sel = br_taken;
                rf_we      = !(cls_br || cls_st);
                state_nx   = (halt_req || halt_pend) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                done = !err_q;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Opcode class, branch decision, timeout, error, retire count, halt latch
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cls_ld    <= 1'b0;
            cls_st    <= 1'b0;
            cls_br    <= 1'b0;
            br_taken  <= 1'b0;
            halt_pend <= 1'b0;
            err_q     <= 1'b0;
            tcnt      <= '0;
            ret_q     <= '0;
        end else begin
            if (state == S_DECODE) begin
                cls_ld <= (op == kLDM);
                cls_st <= (op == kSTR);
                cls_br <= (op == kBNE);
            end
            if (state == S_EXEC) begin
                br_taken <= cls_br && !zero;
                tcnt     <= '0;
            end
            if (state == S_MEM && !mem_ack) begin
                tcnt <= tcnt + TW'(1);
                if (mem_last) err_q <= 1'b1;
            end
            if (state == S_WB) ret_q <= ret_q + CNT_W'(1);
            if (busy && halt_req) halt_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl.
// Expected write-back records are queued per instruction and popped at WB.
module tb_cpu_seq_ctrl;
    import cpu_defs_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        pc_en, branch_sel, ir_we, rf_we;
    logic        mem_req, mem_we, busy, done, err;
    logic [15:0] retired;
    logic [8:0]  outs;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_ret = 16'd0;

    typedef struct packed {
        logic        rf;
        logic        bs;
        logic [15:0] ret;
    } wb_t;

    wb_t sb[$];

    cpu_seq_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .CLK(CLK),
        .Reset_n(Reset_n),
        .start(start),
        .halt_req(halt_req),
        .op(op),
        .zero(zero),
        .mem_ack(mem_ack),
        .pc_en(pc_en),
        .branch_sel(branch_sel),
        .ir_we(ir_we),
        .rf_we(rf_we),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .busy(busy),
        .done(done),
        .err(err),
        .retired(retired)
    );

    assign outs = {pc_en, branch_sel, ir_we, rf_we, mem_req,
                   mem_we, busy, done, err};

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut(input string tag);
        Reset_n  = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        mem_ack  = 1'b0;
        tick();
        tick();
        chk({tag, "/rst_outs"}, 32'(outs), 32'd0);
        chk({tag, "/rst_retired"}, 32'(retired), 32'd0);
        Reset_n = 1'b1;
        exp_ret = 16'd0;
        tick();
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called with the DUT in FETCH at a falling edge
    task automatic run(input logic [2:0] o, input logic z, input int ack_at,
                       input logic hlt, input string tag);
        wb_t  e;
        wb_t  g;
        int   k;
        logic is_mem;
        is_mem  = (o == kLDM) || (o == kSTR);
        exp_ret = exp_ret + 16'd1;
        e.rf    = !((o == kBNE) || (o == kSTR));
        e.bs    = (o == kBNE) && !z;
        e.ret   = exp_ret;
        sb.push_back(e);
        chk({tag, "/fetch_ir_we"}, 32'(ir_we), 32'd1);
        op   = o;
        zero = z;
        tick();
        chk({tag, "/dec_ir_busy"}, 32'({ir_we, busy}), 32'b01);
        if (hlt) halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk({tag, "/exec_quiet"}, 32'({pc_en, rf_we, mem_req}), 32'd0);
        tick();
        if (is_mem) begin
            k = 0;
            while (mem_req === 1'b1 && k < 40) begin
                k++;
                chk({tag, "/mem_we"}, 32'(mem_we), 32'(o == kSTR));
                if (k == ack_at) mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end
            chk({tag, "/req_cycles"}, 32'(k), 32'(ack_at));
        end
        g = sb.pop_front();
        chk({tag, "/wb_pc_en"}, 32'({pc_en, mem_req}), 32'b10);
        chk({tag, "/wb_rf_we"}, 32'(rf_we), 32'(g.rf));
        chk({tag, "/wb_bsel"}, 32'(branch_sel), 32'(g.bs));
        tick();
        chk({tag, "/retired"}, 32'(retired), 32'(g.ret));
        if (hlt) chk({tag, "/halt_done"}, 32'({busy, done, err}), 32'b010);
        else     chk({tag, "/next_fetch"}, 32'(ir_we), 32'd1);
    endtask

    initial begin
        int  k;
        logic seen_rf;

        // ALU op with halt pulsed in DECODE
        reset_dut("a");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("a/idle_ack_ignored", 32'(busy), 32'd0);
        kick();
        run(3'd1, 1'b0, 0, 1'b1, "alu_halt");
        kick();
        tick();
        chk("a/start_in_halt", 32'({busy, done}), 32'b01);
        chk("a/retired_hold", 32'(retired), 32'd1);

        // Load, store, both branch outcomes, then reset mid-MEM
        reset_dut("b");
        kick();
        run(kLDM, 1'b0, 3, 1'b0, "ld3");
        run(kSTR, 1'b0, 1, 1'b0, "st1");
        start = 1'b1;
        run(kBNE, 1'b0, 0, 1'b0, "bne_z0");
        start = 1'b0;
        run(kBNE, 1'b1, 0, 1'b0, "bne_z1");
        op = kSTR;
        tick();
        tick();
        tick();
        chk("b/mem_pre_rst", 32'({mem_req, mem_we}), 32'b11);
        #2 Reset_n = 1'b0;
        #1 chk("b/async_req_drop", 32'(mem_req), 32'd0);
        chk("b/async_outs", 32'(outs), 32'd0);
        chk("b/async_retired", 32'(retired), 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        exp_ret = 16'd0;
        tick();
        chk("b/idle_after_rst", 32'(busy), 32'd0);
        kick();
        run(3'd2, 1'b0, 0, 1'b1, "alu_after_rst");

        // Ack on the last allowed cycle, then a real timeout
        reset_dut("c");
        kick();
        run(kLDM, 1'b0, 15, 1'b0, "ld_ack15");
        op = kLDM;
        tick();
        tick();
        tick();
        k = 0;
        seen_rf = 1'b0;
        while (mem_req === 1'b1 && k < 40) begin
            k++;
            if (rf_we !== 1'b0) seen_rf = 1'b1;
            tick();
        end
        chk("c/to_cycles", 32'(k), 32'd15);
        chk("c/to_flags", 32'({busy, done, err}), 32'b001);
        chk("c/to_rf_we", 32'(seen_rf), 32'd0);
        chk("c/to_retired", 32'(retired), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("c/halt_sticky", 32'(outs), 32'b000000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 9-bit CPU core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB, and gates the PC, IR, register-file and data-memory enables.
- Decodes load/store/branch classes from the 3-bit opcode using the definitions package constants (kLDM, kSTR, kBNE).
- Runs the req/ack handshake with data memory, counts retired instructions and reports done/error to the test harness.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack before error (>=1).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin execution from IDLE; one-cycle pulse.
- halt_req  input  1  stop after the current instruction retires.
- op  input  3  opcode field of IR, valid from DECODE onward.
- zero  input  1  ALU zero flag, sampled in EXEC.
- mem_ack  input  1  data memory completion.
- pc_en  output  1  advance PC (sequential or branch target).
- branch_sel  output  1  PC loads branch target when pc_en=1.
- ir_we  output  1  load instruction register.
- rf_we  output  1  register-file write enable.
- mem_req  output  1  data memory request.
- mem_we  output  1  data memory write (valid with mem_req).
- busy  output  1  high in any state except IDLE/HALT.
- done  output  1  high in HALT with no error.
- err  output  1  sticky memory-timeout error.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; all outputs 0; retired=0; timeout counter=0. Reset mid-handshake drops mem_req immediately.
- All enables are Moore outputs decoded from the state register, plus the registered opcode class for WB/MEM.
- States and transitions:
  - IDLE: start=1 -> FETCH. Otherwise stay.
  - FETCH: ir_we=1 for one cycle -> DECODE.
  - DECODE: latch class (ld = op==kLDM, st = op==kSTR, br = op==kBNE) -> EXEC.
  - EXEC:
    - ld or st -> MEM.
    - br -> WB with branch_sel = ~zero, registered here.
    - Otherwise -> WB.
  - MEM: mem_req=1; mem_we=st. Both held stable until mem_ack.
    - mem_ack=1 -> WB.
    - Timeout counter increments each MEM cycle without ack. When it reaches MEM_TIMEOUT with no ack: err<=1 -> HALT.
    - An ack arriving in the same cycle as the timeout wins: go to WB, no error.
- WB:
  - rf_we=1 unless the class is br or st.
  - pc_en=1; branch_sel=registered branch-taken.
  - retired increments; wraps modulo 2^CNT_W.
  - Next state: halt_req=1 (sampled this cycle or latched earlier) -> HALT; else -> FETCH.
- Latency: 4 cycles per ALU/branch instruction; 5 + ack-wait cycles per load/store.
- halt_req behaviour:
  - Latched into a pending flag in any busy state.
  - Never aborts a MEM handshake.
  - Ignored in IDLE/HALT.
- HALT: busy=0; done=~err; all enables 0. Only Reset_n leaves HALT; start is ignored.
- Timeout counter clears on entry to MEM.
- mem_ack outside MEM is ignored.
- start while busy is ignored.

Test Plan:
- Reset, then start, with op = a non-ld/st/br ALU op, halt_req pulsed during DECODE:
  - ir_we in cycle 1, rf_we and pc_en in cycle 4, then HALT.
  - done=1, retired=1.
- Load: op=kLDM, mem_ack asserted 3 cycles after mem_req rises:
  - mem_req=1 for exactly 3 cycles; mem_we=0.
  - WB has rf_we=1; retired=1.
- Store: op=kSTR, immediate ack:
  - mem_req=1 and mem_we=1 for one cycle.
  - WB has rf_we=0 and pc_en=1.
- Branch: op=kBNE with zero=0 -> WB has branch_sel=1, rf_we=0. Repeat with zero=1 -> branch_sel=0.
- Timeout: op=kLDM, mem_ack never asserted, MEM_TIMEOUT=15:
  - After 15 MEM cycles, err=1, state HALT.
  - done=0, rf_we never asserted, retired unchanged.
- Reset_n pulled low mid-MEM: mem_req drops asynchronously; all outputs 0 and retired=0. After release, start runs normally.
